// File: rtl/demux2_n_buf_pkg.sv
// demux2_n_buf_pkg: destination encoding and buffer occupancy helpers
package demux2_n_buf_pkg;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  typedef logic [1:0] occ_t;
  function automatic logic has_room(input occ_t occ);
    return occ != 2'd2;
  endfunction
endpackage

// File: rtl/demux2_n_buf_if.sv
// demux2_n_buf_if: input stream plus the two steered output streams
interface demux2_n_buf_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_sel;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_data;
  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data
  );
  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data
  );
endinterface

// File: rtl/demux2_n_buf_fifo2_n.sv
// fifo2_n: 2-entry FIFO, e0 is always the head so dout needs no read mux
module fifo2_n
  import demux2_n_buf_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output occ_t         count
);
  logic [N-1:0] e0, e1, e0_n, e1_n;
  occ_t         count_n;
  logic         wr, rd;
  // next state: a pop shifts e1 into the head, a push lands in the first free slot after the pop
  always_comb begin
    wr      = push && (has_room(count) || pop);
    rd      = pop && count != 2'd0;
    count_n = count + occ_t'(wr) - occ_t'(rd);
    e0_n    = rd ? (count == 2'd2 ? e1 : (wr ? din : e0)) : (wr && count == 2'd0 ? din : e0);
    e1_n    = wr && (count - occ_t'(rd)) == 2'd1 ? din : e1;
  end
  // storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      e0    <= e0_n;
      e1    <= e1_n;
      count <= count_n;
    end
  end
  assign dout = e0;
endmodule

// File: rtl/demux2_n_buf.sv
// demux2_n_buf: registered 1-to-2 demux with independent 2-entry output buffers
module demux2_n_buf
  import demux2_n_buf_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  demux2_n_buf_if.slave    bus,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);
  occ_t a_occ, b_occ;
  logic push, a_pop, b_pop;
  // ready looks only at registered occupancy of the selected buffer, never at a_ready/b_ready
  always_comb begin
    bus.in_ready = bus.in_sel == SEL_A ? has_room(a_occ) : has_room(b_occ);
    push         = bus.in_valid && bus.in_ready;
    bus.a_valid  = a_occ != 2'd0;
    bus.b_valid  = b_occ != 2'd0;
    a_pop        = bus.a_valid && bus.a_ready;
    b_pop        = bus.b_valid && bus.b_ready;
  end
  fifo2_n #(.N(N)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && bus.in_sel == SEL_A),
    .pop   (a_pop),
    .din   (bus.in_data),
    .dout  (bus.a_data),
    .count (a_occ)
  );
  fifo2_n #(.N(N)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && bus.in_sel == SEL_B),
    .pop   (b_pop),
    .din   (bus.in_data),
    .dout  (bus.b_data),
    .count (b_occ)
  );
  // delivered-word counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      a_cnt <= a_cnt + CNT_W'(a_pop);
      b_cnt <= b_cnt + CNT_W'(b_pop);
    end
  end
endmodule
